// File: rtl/instr_pipe_pkg.sv
// Shared types for the decode-to-retire instruction pipe.
`default_nettype none

package instr_pipe_pkg;

  typedef logic [31:0] instruction_t;

  typedef struct packed {
    logic         valid;
    instruction_t payload;
  } stage_t;

  localparam int PIPE_DEPTH_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/pipe_stage.sv
// One valid+payload register of the instruction pipe; kill masks the held entry.
`default_nettype none

module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             kill,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             v_q;
  logic [WIDTH-1:0] d_q;

  assign valid = v_q & ~kill;
  assign data  = d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else if (adv) begin
      v_q <= in_valid;
      d_q <= in_data;
    end else begin
      // a stalled entry that is killed turns into a bubble in place
      v_q <= valid;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_pipe.sv
// DEPTH-stage instruction pipe with backpressure, bubble collapse, per-stage
// flush, live occupancy and a retire order counter for RVFI.
`default_nettype none

module instr_pipe
  import instr_pipe_pkg::*;
#(
  parameter int DEPTH   = PIPE_DEPTH_DEFAULT,
  parameter int WIDTH   = $bits(instruction_t),
  parameter int ORDER_W = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [WIDTH-1:0]           i_in_data,
  input  logic [DEPTH-1:0]           i_flush_mask,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [WIDTH-1:0]           o_out_data,
  output logic [ORDER_W-1:0]         o_out_order,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]   ve;
  logic [DEPTH-1:0]   adv;
  logic [WIDTH-1:0]   d [DEPTH];
  logic [OCC_W-1:0]   occ;
  logic [ORDER_W-1:0] order;
  logic               retire;

  // adv[k] is set when any stage at or below k is empty, or the sink takes data
  always_comb begin
    logic hole;
    hole = i_out_ready;
    adv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hole   = hole | ~ve[k];
      adv[k] = hole;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (k == 0) begin : g_head
      assign up_v = i_in_valid & adv[0];
      assign up_d = i_in_data;
    end else begin : g_body
      assign up_v = ve[k-1];
      assign up_d = d[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .adv      (adv[k]),
      .kill     (i_flush_mask[k]),
      .in_valid (up_v),
      .in_data  (up_d),
      .valid    (ve[k]),
      .data     (d[k])
    );
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(ve[k]);
    end
  end

  assign retire = ve[DEPTH-1] & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      order <= '0;
    end else if (retire) begin
      order <= order + ORDER_W'(1);
    end
  end

  assign o_in_ready  = adv[0];
  assign o_out_valid = ve[DEPTH-1];
  assign o_out_data  = d[DEPTH-1];
  assign o_out_order = order;
  assign o_occupancy = occ;

endmodule

`default_nettype wire

// File: tb/tb_instr_pipe.sv
// Directed self-checking bench for instr_pipe (DEPTH=3, ORDER_W=4).
`default_nettype none

module tb_instr_pipe;

  localparam int DEPTH   = 3;
  localparam int WIDTH   = 32;
  localparam int ORDER_W = 4;
  localparam int OCC_W   = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [DEPTH-1:0]   flush_mask;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [ORDER_W-1:0] out_order;
  logic [OCC_W-1:0]   occupancy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ORDER_W(ORDER_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_flush_mask (flush_mask),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_order  (out_order),
    .o_occupancy  (occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush_mask = '0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_order !== 4'd0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: got v=%b ord=%0d occ=%0d rdy=%b, want v=0 ord=0 occ=0 rdy=1",
               out_valid, out_order, occupancy, in_ready);
    end
  endtask

  // Continuous push of 5 entries with the sink always ready.
  task automatic test_streaming();
    int j, eocc;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 5);
      in_data  = 32'hA1 + i;
      #1;
      j = i - 3;
      eocc = 0;
      for (int m = i - 3; m <= i - 1; m++) if (m >= 0 && m <= 4) eocc++;
      tests++;
      if (occupancy !== eocc[OCC_W-1:0]) begin
        fails++;
        $display("FAIL stream_occ step %0d: got %0d want %0d", i, occupancy, eocc);
      end
      if (i >= 3) begin
        tests++;
        if (j <= 4) begin
          if (out_valid !== 1'b1 || out_data !== 32'hA1 + j || out_order !== j[ORDER_W-1:0]) begin
            fails++;
            $display("FAIL stream_out step %0d: got v=%b d=%h ord=%0d, want v=1 d=%h ord=%0d",
                     i, out_valid, out_data, out_order, 32'hA1 + j, j);
          end
        end else if (out_valid !== 1'b0 || out_order !== 4'd5) begin
          fails++;
          $display("FAIL stream_empty step %0d: got v=%b ord=%0d, want v=0 ord=5",
                   i, out_valid, out_order);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 32'hB2; #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_before_park: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
    tick();
    in_data = 32'hB3; #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hB1 || occupancy !== 2'd2 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_parked: got v=%b d=%h occ=%0d rdy=%b, want v=1 d=b1 occ=2 rdy=1",
               out_valid, out_data, occupancy, in_ready);
    end
    tick();
    in_data = 32'hB4; #1;
    tests++;
    if (in_ready !== 1'b0 || occupancy !== 2'd3 || out_data !== 32'hB1) begin
      fails++;
      $display("FAIL bp_full: got rdy=%b occ=%0d d=%h, want rdy=0 occ=3 d=b1",
               in_ready, occupancy, out_data);
    end
    tick();
    in_valid = 1'b0; #1;
    tests++;
    if (occupancy !== 2'd3 || out_data !== 32'hB1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold: got occ=%0d d=%h rdy=%b, want occ=3 d=b1 rdy=0",
               occupancy, out_data, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'hB1 + i || out_order !== i[ORDER_W-1:0]) begin
        fails++;
        $display("FAIL bp_drain %0d: got v=%b d=%h ord=%0d, want v=1 d=%h ord=%0d",
                 i, out_valid, out_data, out_order, 32'hB1 + i, i);
      end
      tick();
    end
    tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL bp_no_dup: got v=%b occ=%0d, want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hC1 + i;
      tick();
    end
    in_valid = 1'b0;
    flush_mask = 3'b010; #1;
    tests++;
    if (occupancy !== 2'd2) begin
      fails++;
      $display("FAIL flush_occ: got %0d want 2", occupancy);
    end
    tick();
    flush_mask = '0; #1;
    tests++;
    if (in_ready !== 1'b1 || occupancy !== 2'd2 || out_data !== 32'hC1) begin
      fails++;
      $display("FAIL flush_after: got rdy=%b occ=%0d d=%h, want rdy=1 occ=2 d=c1",
               in_ready, occupancy, out_data);
    end
    out_ready = 1'b1; #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hC1 || out_order !== 4'd0) begin
      fails++;
      $display("FAIL flush_ret0: got v=%b d=%h ord=%0d, want v=1 d=c1 ord=0",
               out_valid, out_data, out_order);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hC3 || out_order !== 4'd1) begin
      fails++;
      $display("FAIL flush_ret1: got v=%b d=%h ord=%0d, want v=1 d=c3 ord=1",
               out_valid, out_data, out_order);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_order !== 4'd2) begin
      fails++;
      $display("FAIL flush_end: got v=%b ord=%0d, want v=0 ord=2", out_valid, out_order);
    end
  endtask

  task automatic test_output_flush();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hD1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hD1 || out_order !== 4'd0) begin
      fails++;
      $display("FAIL oflush_pre: got v=%b d=%h ord=%0d, want v=1 d=d1 ord=0",
               out_valid, out_data, out_order);
    end
    flush_mask = 3'b100; #1;
    tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL oflush_kill: got v=%b occ=%0d, want v=0 occ=0", out_valid, occupancy);
    end
    tick();
    flush_mask = '0; #1;
    tests++;
    if (out_valid !== 1'b0 || out_order !== 4'd0) begin
      fails++;
      $display("FAIL oflush_order: got v=%b ord=%0d, want v=0 ord=0", out_valid, out_order);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'hE1 + i;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; #1;
    tests++;
    if (in_ready !== 1'b0 || occupancy !== 2'd3 || out_order !== 4'd2 || out_data !== 32'hE3) begin
      fails++;
      $display("FAIL rmid_full: got rdy=%b occ=%0d ord=%0d d=%h, want rdy=0 occ=3 ord=2 d=e3",
               in_ready, occupancy, out_order, out_data);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_order !== 4'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_after: got v=%b occ=%0d ord=%0d rdy=%b, want v=0 occ=0 ord=0 rdy=1",
               out_valid, occupancy, out_order, in_ready);
    end
    in_valid = 1'b1; in_data = 32'hF1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b1; #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hF1 || out_order !== 4'd0) begin
      fails++;
      $display("FAIL rmid_first: got v=%b d=%h ord=%0d, want v=1 d=f1 ord=0",
               out_valid, out_data, out_order);
    end
    tick();
  endtask

  task automatic test_order_wrap();
    int j;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 17);
      in_data  = 32'h100 + i;
      #1;
      j = i - 3;
      if (j >= 0) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h100 + j || out_order !== j[ORDER_W-1:0]) begin
          fails++;
          $display("FAIL wrap %0d: got v=%b d=%h ord=%0d, want v=1 d=%h ord=%0d",
                   j, out_valid, out_data, out_order, 32'h100 + j, j % 16);
        end
      end
      tick();
    end
    tests++;
    if (out_order !== 4'd1) begin
      fails++;
      $display("FAIL wrap_final: got ord=%0d want 1", out_order);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_output_flush();
    test_reset_mid();
    test_order_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_pipe.md
Name: instr_pipe

Overview:
- Parametrised successor to the fixed two-register instruction delay chain between decode and retirement.
- Carries DEPTH stages of instruction payload, each with a valid bit, and adds:
  - valid/ready backpressure;
  - bubble collapse (an empty stage absorbs from upstream while downstream stalls);
  - per-stage flush;
  - an occupancy count;
  - a 64-bit retire order counter feeding the RVFI order output.
- Sits between decode and the retire/RVFI logic in cpu.

Parameters:
- DEPTH, 2: number of pipeline stages. Legal range is 1..16.
- WIDTH, $bits(instruction_t): payload width per stage.
- ORDER_W, 64: width of the retire order counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_in_valid  input  1  upstream has a payload.
- o_in_ready  output  1  stage 0 accepts this cycle.
- i_in_data  input  WIDTH  payload from decode.
- i_flush_mask  input  DEPTH  bit k kills the entry currently in stage k.
- o_out_valid  output  1  last stage holds a live entry.
- i_out_ready  input  1  retire side consumes this cycle.
- o_out_data  output  WIDTH  last-stage payload.
- o_out_order  output  ORDER_W  order number of the entry on o_out_data.
- o_occupancy  output  $clog2(DEPTH+1)  live entries after flush masking.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - all stage valids and the order counter clear to 0;
  - stage data is don't-care; implement it as cleared to 0 for determinism;
  - the cycle after reset: o_out_valid=0, o_out_order=0, o_occupancy=0, o_in_ready=1.
- Reset mid-operation discards every entry, with no retirement. Reset has priority over flush and advance.
- Effective valid: ve[k] = v[k] & ~i_flush_mask[k]. All decisions below use ve.
- Advance enables:
  - adv[DEPTH-1] = ~ve[DEPTH-1] | i_out_ready.
  - adv[k] = ~ve[k] | adv[k+1] for k < DEPTH-1.
  - o_in_ready = adv[0]. This path is combinational from i_out_ready and i_flush_mask; there is no registered skid.
- Stage update at the rising edge:
  - if adv[k]: v[k] <= upstream ve, and d[k] <= upstream data;
  - for stage 0, upstream ve is i_in_valid & o_in_ready, and upstream data is i_in_data;
  - else: v[k] <= ve[k] and d[k] holds. A stalled, flushed stage therefore becomes a bubble.
- A flushed entry never moves downstream and never retires. The entry that moves into stage k in the same cycle is not affected by i_flush_mask[k].
- Output port:
  - o_out_valid = ve[DEPTH-1], and o_out_data = d[DEPTH-1];
  - retire fires when o_out_valid & i_out_ready;
  - o_out_order = order counter value; the counter increments by 1 on each retire and wraps modulo 2^ORDER_W.
- Latency: with no stalls, an entry accepted at edge N appears on o_out_valid after edge N+DEPTH-1.
  - DEPTH=1 gives one-cycle latency.
  - Throughput is 1 entry per cycle.
- Full: all ve set and i_out_ready=0 → o_in_ready=0, all state held.
- Full with i_out_ready=1 → simultaneous accept and retire; occupancy is unchanged.
- Empty: o_out_valid=0. o_out_order is still driven and is the value the next retire will use.
- o_occupancy = popcount(ve). It is combinational and reflects the flush mask in the current cycle.
- Data is not cleared on bubbles. Consumers must qualify data with valid.
- RVFI binding in cpu: rvfi_valid = o_out_valid & i_out_ready, and rvfi_order = o_out_order.

Decomposition:
- Shared package (existing cpu package) holds:
  - instruction_t;
  - a stage_t struct {logic valid; instruction_t payload};
  - localparam PIPE_DEPTH_DEFAULT = 2.
- One natural sub-module: pipe_stage.
  - It is a single valid+data register with inputs adv, kill, in_valid, in_data.
  - It is instantiated DEPTH times under a generate loop.
- Advance chain, popcount and order counter stay in instr_pipe.

Test Plan:
- Streaming: DEPTH=3, i_out_ready=1, push 0xA1,0xA2,0xA3 on consecutive cycles → outputs on cycles 3,4,5 with orders 0,1,2; occupancy steady at 3 after fill.
- Backpressure and bubble collapse:
  - Setup: DEPTH=3, hold i_out_ready=0, push 0xB1 then a one-cycle gap then 0xB2,0xB3.
  - During the stall: 0xB1 parks in stage 2, the bubble collapses, and o_in_ready drops only after all 3 stages are full.
  - After releasing i_out_ready: 0xB1,0xB2,0xB3 retire in order with no duplicates.
- Flush:
  - Setup: DEPTH=3, stages hold C1(s2), C2(s1), C3(s0), i_out_ready=0, i_flush_mask=3'b010 for one cycle.
  - Same cycle: occupancy=2.
  - Next cycle: C3 has moved into s1, s0 is free, and o_in_ready=1.
  - On release: retires are C1 (order 0), then C3 (order 1).
- Output flush: i_flush_mask[DEPTH-1]=1 while o_out_valid was 1 and i_out_ready=1 → o_out_valid=0 that cycle, order does not increment.
- Reset mid-stream: full pipe, i_rst_n=0 for one edge → o_out_valid=0, occupancy=0, order=0, o_in_ready=1; the first entry pushed afterwards retires with order 0.
- Order wrap: ORDER_W=4, retire 17 entries → order sequence 0..15, then 0.
